dmem_responder: RTL

Data-memory responder on the far side of the MEM-stage load/store interface. It accepts one word-addressed request at a time from the memory stage and commits writes with per-byte lane enables. It returns read data after a programmable latency and raises a stall request so the pipeline holds until the access completes. It replaces the ideal zero-wait data RAM so the stall path of the pipeline is exercised.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_bank.sv | 32 +++
 rtl/dmem_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// byte-lane legality and lane masking.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Byte, aligned halfword or full word; anything else is a malformed request.
  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [31:0] word, input logic [3:0] sel);
    logic [31:0] masked;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = sel[i] ? word[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/dmem_responder_bank.sv
// Word storage as four byte-wide synchronous RAMs with per-lane write enable
// and a registered read port; contents are never reset.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    sel,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en && we && sel[i]) begin
        ram[addr] <= wdata[8*i +: 8];
      end
      if (en && !we) begin
        q <= ram[addr];
      end
    end
  end

  assign rdata = {g_lane[3].q, g_lane[2].q, g_lane[1].q, g_lane[0].q};

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, waits LATENCY
// cycles, commits the access, then pulses ready for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        stallreq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture, access;

  logic        req_we;
  logic [29:0] req_word;
  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic        req_err;
  logic [31:0] bank_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr_i[1:0];

  assign req_err = !sel_legal(req_sel) || ({2'b00, req_word} >= 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DMEM_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      req_we   <= mem_we_i;
      req_word <= mem_addr_i[31:2];
      req_sel  <= mem_sel_i;
      req_data <= mem_data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (mem_ce_i) begin
          capture   = 1'b1;
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          // Gating with rst drops a write that coincides with a reset edge.
          access    = rst && !req_err;
          state_nxt = DMEM_RESP;
        end
      end
      DMEM_RESP: state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  dmem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .en    (access),
    .we    (req_we),
    .addr  (req_word[AW-1:0]),
    .sel   (req_sel),
    .wdata (req_data),
    .rdata (bank_rdata)
  );

  assign mem_ready_o = (state == DMEM_RESP);
  assign mem_err_o   = (state == DMEM_RESP) && req_err;
  assign mem_data_o  = ((state == DMEM_RESP) && !req_err && !req_we)
                       ? lane_mask(bank_rdata, req_sel) : ZERO_WORD;
  assign stallreq_o  = rst && mem_ce_i && (state != DMEM_RESP);

endmodule
